// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer and the processor interface.
package proc_pkg;

    // Instruction width, matches the processor din port.
    localparam int unsigned DW = 16;

    // Instruction field positions: opcode[15:13], imm[12], rX[11:9], rY/imm[8:0].
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned IMM_BIT = 12;
    localparam int unsigned RX_MSB  = 11;
    localparam int unsigned RX_LSB  = 9;
    localparam int unsigned RY_MSB  = 8;
    localparam int unsigned RY_LSB  = 0;

    // Opcodes understood by the processor.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Sequencer state encoding.
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFinish,
        StError
    } seq_state_e;

    // Extract the opcode field from an instruction word.
    function automatic logic [2:0] get_opcode(input logic [DW-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory: register array with synchronous write and asynchronous read.
// Contents are intentionally not reset so a loaded program survives reset.
module seq_prog_mem #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port; a read in the same cycle sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues a stored program to the processor one word per
// run pulse, waiting for done between words, with a per-instruction timeout.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned DW      = proc_pkg::DW,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          run,
    output logic [DW-1:0] din,
    input  logic          done,
    output logic          busy,
    output logic [AW-1:0] pc,
    output logic          seq_done,
    output logic          err
);

    localparam int unsigned TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   DepthLen  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LenOne    = (AW + 1)'(1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] din_q, din_d;
    logic [AW:0]   len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          mem_we;

    // Loader writes only land while the sequencer is not driving the processor.
    assign mem_we = wr_en && (state_q == StIdle || state_q == StError);

    seq_prog_mem #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_prog_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .waddr_i(wr_addr),
        .wdata_i(wr_data),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    // Next-state, program counter, instruction latch and timeout timer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        len_d   = len_q;
        timer_d = '0;
        rd_addr = pc_q + AW'(1);
        unique case (state_q)
            StIdle: begin
                rd_addr = '0;
                if (start) begin
                    if (prog_len == '0) begin
                        state_d = StFinish;
                    end else begin
                        len_d   = (prog_len > DepthLen) ? DepthLen : prog_len;
                        pc_d    = '0;
                        din_d   = rd_data;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                // Timer reads 0 here; counting continues through WAIT.
                timer_d = timer_q + TW'(1);
                state_d = StWait;
            end
            StWait: begin
                // done takes priority over an expiring timer.
                if (done) begin
                    if ({1'b0, pc_q} == len_q - LenOne) begin
                        state_d = StFinish;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        din_d   = rd_data;
                        state_d = StIssue;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = StError;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            din_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            len_q   <= len_d;
            timer_q <= timer_d;
        end
    end

    assign run      = (state_q == StIssue);
    assign busy     = (state_q == StIssue) || (state_q == StWait);
    assign seq_done = (state_q == StFinish);
    assign err      = (state_q == StError);
    assign din      = din_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with a simple processor done model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        run;
    logic [15:0] din;
    logic        done = 1'b0;
    logic        busy;
    logic [3:0]  pc;
    logic        seq_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Processor model: done pulses done_delay cycles after a run cycle.
    bit model_en   = 1'b0;
    int done_delay = 2;
    int pend       = 0;

    // Per-cycle capture of a sequence run.
    logic [15:0] run_din [$];
    int          run_cyc [$];
    int          done_cyc [$];
    int          sdone_cyc [$];
    int          err_cyc;
    logic [15:0] din_h  [64];
    logic        busy_h [64];
    logic [3:0]  pc_h   [64];
    logic        err_h  [64];

    instr_sequencer #(
        .TIMEOUT(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .prog_len(prog_len),
        .start   (start),
        .run     (run),
        .din     (din),
        .done    (done),
        .busy    (busy),
        .pc      (pc),
        .seq_done(seq_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (model_en && run) pend = done_delay;
    end

    always @(posedge clk) begin
        #1;
        done = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) done = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    // Pulse start in cycle 0 and capture ncyc cycles. act: 1 = write FFFF to
    // address 1 in act_cyc, 2 = reset in act_cyc, 3 = write AAAA to address 0
    // together with start.
    task automatic run_seq(input logic [4:0] len, input int ncyc, input int act_cyc,
                           input int act);
        run_din.delete();
        run_cyc.delete();
        done_cyc.delete();
        sdone_cyc.delete();
        err_cyc = -1;
        tick;
        prog_len = len;
        start = 1'b1;
        if (act == 3) begin
            wr_en = 1'b1;
            wr_addr = 4'd0;
            wr_data = 16'hAAAA;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (run) begin
                run_din.push_back(din);
                run_cyc.push_back(i);
            end
            if (done) done_cyc.push_back(i);
            if (seq_done) sdone_cyc.push_back(i);
            if (err && err_cyc < 0) err_cyc = i;
            din_h[i]  = din;
            busy_h[i] = busy;
            pc_h[i]   = pc;
            err_h[i]  = err;
            tick;
            start = 1'b0;
            wr_en = 1'b0;
            reset = 1'b0;
            if (i + 1 == act_cyc) begin
                if (act == 1) begin
                    wr_en = 1'b1;
                    wr_addr = 4'd1;
                    wr_data = 16'hFFFF;
                end else if (act == 2) begin
                    reset = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b want 0", run); end
        n_checks++; if (din !== 16'h0) begin n_fail++; $display("FAIL reset_din got %h want 0000", din); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", pc); end
        n_checks++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done got %b want 0", seq_done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_basic;
        logic [15:0] exp_din [4];
        exp_din[0] = 16'h10ff;
        exp_din[1] = 16'h20ff;
        exp_din[2] = 16'h40ff;
        exp_din[3] = 16'h60ff;
        write_mem(4'd0, 16'h10ff);
        write_mem(4'd1, 16'h20ff);
        write_mem(4'd2, 16'h40ff);
        write_mem(4'd3, 16'h60ff);
        model_en = 1'b1;
        done_delay = 2;
        run_seq(5'd4, 20, -1, 0);
        n_checks++;
        if (run_din.size() != 4) begin
            n_fail++; $display("FAIL basic_run_count got %0d want 4", run_din.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (run_din[k] !== exp_din[k]) begin
                    n_fail++; $display("FAIL basic_din%0d got %h want %h", k, run_din[k], exp_din[k]);
                end
            end
            n_checks++;
            if (run_cyc[0] != 1) begin
                n_fail++; $display("FAIL basic_first_run got cycle %0d want 1", run_cyc[0]);
            end
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (done_cyc.size() < k || run_cyc[k] != done_cyc[k-1] + 1) begin
                    n_fail++; $display("FAIL basic_run_after_done%0d got cycle %0d want done+1", k, run_cyc[k]);
                end
            end
        end
        n_checks++;
        if (sdone_cyc.size() != 1 || sdone_cyc[0] != 13) begin
            n_fail++; $display("FAIL basic_seq_done got %0d pulses want 1 at cycle 13", sdone_cyc.size());
        end
        n_checks++;
        if (err_cyc != -1) begin
            n_fail++; $display("FAIL basic_err got set at cycle %0d want never", err_cyc);
        end
    endtask

    task automatic test_write_while_busy;
        model_en = 1'b1;
        done_delay = 2;
        run_seq(5'd2, 12, 2, 1);
        n_checks++;
        if (run_din.size() != 2) begin
            n_fail++; $display("FAIL wbusy_run_count got %0d want 2", run_din.size());
        end else if (run_din[1] !== 16'h20ff) begin
            n_fail++; $display("FAIL wbusy_second_din got %h want 20ff", run_din[1]);
        end
    endtask

    task automatic test_reset_mid_run;
        model_en = 1'b1;
        done_delay = 2;
        run_seq(5'd4, 14, 8, 2);
        n_checks++;
        if (run_cyc.size() != 3) begin
            n_fail++; $display("FAIL rstmid_run_count got %0d want 3", run_cyc.size());
        end
        n_checks++; if (busy_h[9] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy_h[9]); end
        n_checks++; if (pc_h[9] !== 4'd0) begin n_fail++; $display("FAIL rstmid_pc got %0d want 0", pc_h[9]); end
        n_checks++; if (din_h[9] !== 16'h0) begin n_fail++; $display("FAIL rstmid_din got %h want 0000", din_h[9]); end
        n_checks++;
        if (sdone_cyc.size() != 0) begin
            n_fail++; $display("FAIL rstmid_seq_done got %0d pulses want 0", sdone_cyc.size());
        end
        run_seq(5'd1, 8, -1, 0);
        n_checks++;
        if (run_din.size() != 1 || run_din[0] !== 16'h10ff) begin
            n_fail++; $display("FAIL rstmid_restart_din got %0d runs want one run of 10ff", run_din.size());
        end
    endtask

    task automatic test_zero_len;
        model_en = 1'b1;
        run_seq(5'd0, 6, -1, 0);
        n_checks++;
        if (run_cyc.size() != 0) begin
            n_fail++; $display("FAIL zero_run got %0d pulses want 0", run_cyc.size());
        end
        n_checks++;
        if (sdone_cyc.size() != 1 || sdone_cyc[0] != 1) begin
            n_fail++; $display("FAIL zero_seq_done got %0d pulses want 1 at cycle 1", sdone_cyc.size());
        end
    endtask

    task automatic test_clamp;
        for (int a = 4; a < 16; a++) write_mem(4'(a), 16'h0100 + 16'(a));
        model_en = 1'b1;
        done_delay = 1;
        run_seq(5'd17, 40, -1, 0);
        n_checks++;
        if (run_din.size() != 16) begin
            n_fail++; $display("FAIL clamp_run_count got %0d want 16", run_din.size());
        end else if (run_din[15] !== 16'h010f) begin
            n_fail++; $display("FAIL clamp_last_din got %h want 010f", run_din[15]);
        end
        n_checks++;
        if (sdone_cyc.size() != 1 || sdone_cyc[0] != 33) begin
            n_fail++; $display("FAIL clamp_seq_done got %0d pulses want 1 at cycle 33", sdone_cyc.size());
        end
    endtask

    task automatic test_write_with_start;
        model_en = 1'b1;
        done_delay = 2;
        run_seq(5'd1, 6, -1, 3);
        n_checks++;
        if (run_din.size() != 1 || run_din[0] !== 16'h10ff) begin
            n_fail++; $display("FAIL rbw_first_din got %0d runs want one run of 10ff", run_din.size());
        end
        run_seq(5'd1, 6, -1, 0);
        n_checks++;
        if (run_din.size() != 1 || run_din[0] !== 16'hAAAA) begin
            n_fail++; $display("FAIL rbw_new_din got %0d runs want one run of aaaa", run_din.size());
        end
    endtask

    task automatic test_collision;
        model_en = 1'b1;
        done_delay = 7;
        run_seq(5'd1, 12, -1, 0);
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 8) begin
            n_fail++; $display("FAIL collide_done_timing got %0d dones want 1 at cycle 8", done_cyc.size());
        end
        n_checks++;
        if (err_cyc != -1) begin
            n_fail++; $display("FAIL collide_err got set at cycle %0d want never", err_cyc);
        end
        n_checks++;
        if (sdone_cyc.size() != 1 || sdone_cyc[0] != 9) begin
            n_fail++; $display("FAIL collide_seq_done got %0d pulses want 1 at cycle 9", sdone_cyc.size());
        end
    endtask

    task automatic test_timeout;
        model_en = 1'b0;
        run_seq(5'd1, 14, -1, 0);
        n_checks++;
        if (run_cyc.size() != 1 || run_cyc[0] != 1) begin
            n_fail++; $display("FAIL tmo_run got %0d runs want 1 at cycle 1", run_cyc.size());
        end
        n_checks++;
        if (err_cyc != 9) begin
            n_fail++; $display("FAIL tmo_err_cycle got %0d want 9", err_cyc);
        end
        n_checks++; if (busy_h[9] !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy_h[9]); end
        run_seq(5'd1, 6, -1, 0);
        n_checks++;
        if (run_cyc.size() != 0) begin
            n_fail++; $display("FAIL tmo_start_ignored got %0d runs want 0", run_cyc.size());
        end
        n_checks++; if (err_h[5] !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky got %b want 1", err_h[5]); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_cleared got %b want 0", err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_write_while_busy;
        test_reset_mid_run;
        test_zero_len;
        test_clamp;
        test_write_with_start;
        test_collision;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
